hack_mem_bus: RTL
=================

HACK_MEM_BUS -- requirements
Module: hack_mem_bus

Interface
REQ-001 SHALL have parameters: DW=16, data width; AW=16, address width; NS=3, slave channel count; BASE={16'd24576,16'd16384,16'd0}, packed NS*AW base address per channel (channel 0 in LSBs); SIZE={16'd1,16'd8192,16'd16384}, packed NS*AW region size per channel; TIMEOUT=15, maximum wait cycles before forced completion.
REQ-002 SHALL have ports clk in 1, the single clock; rst_n in 1, asynchronous active-low reset.
REQ-003 SHALL have CPU-side ports: cpu_addr in AW; cpu_wdata in DW; cpu_read in 1; cpu_write in 1; cpu_rdata out DW; cpu_stall out 1.
REQ-004 SHALL have slave-side ports: s_sel out NS, one-hot; s_addr out AW, region-relative; s_wdata out DW; s_read out 1; s_write out 1; s_rdata in NS*DW; s_ready in NS.
REQ-005 SHALL have error ports: err_valid out 1; err_code out 2 (01 decode, 10 timeout); err_addr out AW; err_write out 1; err_clear in 1.

Function
REQ-006 SHALL decode channel i hit when BASE_i <= cpu_addr < BASE_i+SIZE_i, with the sum computed in AW+1 bits so no wrap occurs; on overlap the lowest index SHALL win.
REQ-007 SHALL run a two-state FSM, IDLE and RESP.
REQ-008 SHALL accept a request (cpu_read|cpu_write) in IDLE, or in RESP in a cycle where the current response completes; an accepted request SHALL enter RESP next cycle.
REQ-009 SHALL, in the acceptance cycle of a hit, drive s_read/s_write as single-cycle pulses, with s_sel, s_addr=cpu_addr-BASE_i, and s_wdata=cpu_wdata.
REQ-010 SHALL register s_sel and s_addr and hold them through RESP until completion; s_read/s_write SHALL be 0 outside acceptance cycles.
REQ-011 SHALL complete a response in RESP in the first cycle where s_ready of the captured channel is 1; s_ready 1 in the cycle after acceptance gives zero wait states.
REQ-012 SHALL drive cpu_stall = RESP & ~completion, combinationally; no new request SHALL be accepted while cpu_stall=1, and the CPU holds its request.
REQ-013 SHALL drive cpu_rdata from the s_rdata slice of the captured channel; it is valid in the completion cycle.
REQ-014 SHALL, when cpu_read and cpu_write are both 1, treat the access as a write.
REQ-015 SHALL treat a miss as a decode error: no slave strobe; RESP completes in the next cycle with cpu_rdata=0 and no stall.
REQ-016 SHALL count stalled cycles in RESP; when the count reaches TIMEOUT it SHALL force completion with cpu_rdata all-ones and raise a timeout error.
REQ-017 SHALL clear the stall counter on every acceptance.
REQ-018 SHALL make the error sticky. On the first error while err_valid=0 it SHALL set err_valid, err_code, err_addr (the CPU address), and err_write. Later errors SHALL NOT overwrite these fields until err_clear.
REQ-019 SHALL clear err_valid on err_clear; when err_clear and a new error coincide, the new error SHALL be captured.
REQ-020 SHALL let a timeout cleared via err_clear proceed normally; no FSM effect.
REQ-021 SHALL NOT raise an error on an idle cycle (no read/write) with an invalid address.

Reset
REQ-022 SHALL, while rst_n=0, force state IDLE, counter 0, registered s_sel/s_addr 0, err_valid/err_code/err_addr/err_write 0, s_read/s_write 0, and cpu_stall 0.
REQ-023 SHALL, on reset assertion mid-RESP, abort the transaction without completion, then resume in IDLE after deassertion.

Verification
REQ-024 SHALL cover this case: read at addr 16'h0010 with s_ready[0] tied 1. Expected: s_sel=001, s_addr=0x0010, s_read pulse, and next cycle cpu_rdata=s_rdata[0] with cpu_stall=0.
REQ-025 SHALL cover this case: write at 16'h4005 with s_ready[1] low 3 cycles. Expected: s_sel=010, s_addr=0x0005, one s_write pulse, cpu_stall=1 for exactly 3 cycles, then completion.
REQ-026 SHALL cover this case: back-to-back reads at 0x6000 then 0x0001, each with 1-cycle response. Expected: second accepted in the first's completion cycle, zero stall, s_sel 100 then 001.
REQ-027 SHALL cover this case: read at 0x6001 (miss). Expected: no strobe, cpu_rdata=0, err_valid=1, err_code=01, err_addr=0x6001, err_write=0; a later miss at 0x7000 leaves err_addr=0x6001.
REQ-028 SHALL cover this case: read at 0x4000 with s_ready[1] stuck 0. Expected: cpu_stall=1 for 15 cycles, forced completion with cpu_rdata=0xFFFF, err_code=10; err_clear coincident with a new miss recaptures it.
REQ-029 SHALL cover this case: rst_n pulsed low during a stall. Expected: immediate cpu_stall=0, err fields 0, and the next access decodes normally.

Source files
------------

// File: rtl/hack_mem_bus.sv
// CPU-to-slave memory bus bridge: address decode, one-outstanding response FSM,
// wait-state timeout and a sticky error capture register.
module hack_mem_bus #(
    parameter int unsigned         DW      = 16,
    parameter int unsigned         AW      = 16,
    parameter int unsigned         NS      = 3,
    parameter logic [NS*AW-1:0]    BASE    = {16'd24576, 16'd16384, 16'd0},
    parameter logic [NS*AW-1:0]    SIZE    = {16'd1, 16'd8192, 16'd16384},
    parameter int unsigned         TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [AW-1:0]      cpu_addr,
    input  logic [DW-1:0]      cpu_wdata,
    input  logic               cpu_read,
    input  logic               cpu_write,
    output logic [DW-1:0]      cpu_rdata,
    output logic               cpu_stall,
    output logic [NS-1:0]      s_sel,
    output logic [AW-1:0]      s_addr,
    output logic [DW-1:0]      s_wdata,
    output logic               s_read,
    output logic               s_write,
    input  logic [NS*DW-1:0]   s_rdata,
    input  logic [NS-1:0]      s_ready,
    output logic               err_valid,
    output logic [1:0]         err_code,
    output logic [AW-1:0]      err_addr,
    output logic               err_write,
    input  logic               err_clear
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, RESP} state_e;

    state_e          state_q, state_d;
    logic [NS-1:0]   sel_q, sel_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   req_addr_q, req_addr_d;
    logic            write_q, write_d;
    logic            miss_q, miss_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_valid_q, err_valid_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [AW-1:0]   err_addr_q, err_addr_d;
    logic            err_write_q, err_write_d;

    logic [NS-1:0]   dec_sel;
    logic [AW-1:0]   dec_base;
    logic            hit;
    logic [AW:0]     lo, hi;

    logic            req, in_resp, cap_ready, timeout_c, done, accept, new_err;
    logic [DW-1:0]   cap_rdata;
    logic [AW-1:0]   acc_addr;

    // Range decode in AW+1 bits; the first (lowest-index) hit wins.
    always_comb begin
        dec_sel  = '0;
        dec_base = '0;
        hit      = 1'b0;
        lo       = '0;
        hi       = '0;
        for (int unsigned i = 0; i < NS; i++) begin
            lo = {1'b0, BASE[i*AW +: AW]};
            hi = lo + {1'b0, SIZE[i*AW +: AW]};
            if (!hit && ({1'b0, cpu_addr} >= lo) && ({1'b0, cpu_addr} < hi)) begin
                dec_sel[i] = 1'b1;
                dec_base   = BASE[i*AW +: AW];
                hit        = 1'b1;
            end
        end
    end

    // Next-state and outputs.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        req_addr_d  = req_addr_q;
        write_d     = write_q;
        miss_d      = miss_q;
        cnt_d       = cnt_q;
        err_valid_d = err_valid_q;
        err_code_d  = err_code_q;
        err_addr_d  = err_addr_q;
        err_write_d = err_write_q;
        cap_rdata   = '0;
        new_err     = 1'b0;

        for (int unsigned i = 0; i < NS; i++) begin
            if (sel_q[i]) cap_rdata = cap_rdata | s_rdata[i*DW +: DW];
        end

        req       = cpu_read | cpu_write;
        in_resp   = (state_q == RESP);
        cap_ready = |(s_ready & sel_q);
        timeout_c = in_resp & ~miss_q & ~cap_ready & (cnt_q == CW'(TIMEOUT));
        done      = in_resp & (miss_q | cap_ready | timeout_c);
        cpu_stall = in_resp & ~done;
        accept    = rst_n & req & ~cpu_stall;
        acc_addr  = hit ? (cpu_addr - dec_base) : '0;

        if (miss_q)         cpu_rdata = '0;
        else if (timeout_c) cpu_rdata = '1;
        else                cpu_rdata = cap_rdata;

        s_sel   = accept ? dec_sel  : sel_q;
        s_addr  = accept ? acc_addr : addr_q;
        s_wdata = cpu_wdata;
        s_write = accept & hit & cpu_write;
        s_read  = accept & hit & cpu_read & ~cpu_write;

        case (state_q)
            IDLE:    if (accept) state_d = RESP;
            RESP:    if (done && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            sel_d      = dec_sel;
            addr_d     = acc_addr;
            req_addr_d = cpu_addr;
            write_d    = cpu_write;
            miss_d     = ~hit;
            cnt_d      = '0;
        end else if (done) begin
            sel_d  = '0;
            addr_d = '0;
            miss_d = 1'b0;
        end else if (cpu_stall) begin
            cnt_d = cnt_q + CW'(1);
        end

        // A forced timeout belongs to the older transaction, so it outranks a same-cycle miss.
        if (err_clear) err_valid_d = 1'b0;
        new_err = timeout_c | (accept & ~hit);
        if (new_err && (!err_valid_q || err_clear)) begin
            err_valid_d = 1'b1;
            err_code_d  = timeout_c ? 2'b10 : 2'b01;
            err_addr_d  = timeout_c ? req_addr_q : cpu_addr;
            err_write_d = timeout_c ? write_q : cpu_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            addr_q      <= '0;
            req_addr_q  <= '0;
            write_q     <= 1'b0;
            miss_q      <= 1'b0;
            cnt_q       <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'b00;
            err_addr_q  <= '0;
            err_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            req_addr_q  <= req_addr_d;
            write_q     <= write_d;
            miss_q      <= miss_d;
            cnt_q       <= cnt_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_addr_q  <= err_addr_d;
            err_write_q <= err_write_d;
        end
    end

    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign err_addr  = err_addr_q;
    assign err_write = err_write_q;

endmodule
